// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
// Segment words are active-low, segment a at bit 0 through g at bit 6.
package seg_scan_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Entry n holds the glyph for hex value n (b and d in lowercase).
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side content/brightness controls plus the display pin bundle.
// The master is the host/board side; the slave is the scan driver.
interface seg_scan_driver_if
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PWM_BITS   = 4
);

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blank_lz;
    logic [PWM_BITS-1:0]     brightness;
    logic                    update;

    seg7_t                   seg;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits, dp, blink_mask, blank_lz, brightness, update,
        input  seg, dp_n, an, frame_done
    );

    modport slave (
        input  digits, dp, blink_mask, blank_lz, brightness, update,
        output seg, dp_n, an, frame_done
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg_c
);

    assign seg_c = HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: digit scan with dead time, PWM dimming,
// frame-synchronous content updates, leading-zero blanking and blinking.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned PWM_BITS     = 4,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] PWM_FULL = '1;

    // Scan timing state
    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;

    // Host-written shadow copy and the frame-stable active copy
    logic [NUM_DIGITS-1:0][3:0] shadow_digits;
    logic [NUM_DIGITS-1:0]      shadow_dp;
    logic [NUM_DIGITS-1:0]      shadow_blink;
    logic                       shadow_blank_lz;
    logic                       pending;

    logic [NUM_DIGITS-1:0][3:0] act_digits;
    logic [NUM_DIGITS-1:0]      act_dp;
    logic [NUM_DIGITS-1:0]      act_blink;
    logic                       act_blank_lz;

    // Registered pins
    seg7_t                 seg_q;
    logic                  dp_n_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    // Combinational helpers
    logic                  slot_end_c;
    logic                  frame_end_c;
    logic                  pwm_on_c;
    logic                  zero_run_c;
    logic [NUM_DIGITS-1:0] lz_blank_c;
    logic [3:0]            sel_nibble_c;
    seg7_t                 dec_seg_c;
    seg7_t                 seg_c;
    logic                  dp_n_c;
    logic [NUM_DIGITS-1:0] an_c;

    assign slot_end_c  = (presc == PRE_LAST);
    assign frame_end_c = slot_end_c && (idx == IDX_LAST);
    assign pwm_on_c    = (bus.brightness == PWM_FULL) || (pwm_cnt < bus.brightness);

    // Prescaler, digit index, PWM and blink timebase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            idx          <= '0;
            pwm_cnt      <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            frame_done_q <= frame_end_c;
            if (slot_end_c) begin
                presc <= '0;
                idx   <= frame_end_c ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (frame_end_c) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Content moves shadow -> active only on the frame-end edge; an update
    // sampled on that same edge stays pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits   <= '0;
            shadow_dp       <= '0;
            shadow_blink    <= '0;
            shadow_blank_lz <= 1'b0;
            pending         <= 1'b0;
            act_digits      <= '0;
            act_dp          <= '0;
            act_blink       <= '0;
            act_blank_lz    <= 1'b0;
        end else begin
            if (bus.update) begin
                shadow_digits   <= bus.digits;
                shadow_dp       <= bus.dp;
                shadow_blink    <= bus.blink_mask;
                shadow_blank_lz <= bus.blank_lz;
            end
            if (frame_end_c && pending) begin
                act_digits   <= shadow_digits;
                act_dp       <= shadow_dp;
                act_blink    <= shadow_blink;
                act_blank_lz <= shadow_blank_lz;
            end
            pending <= (frame_end_c ? 1'b0 : pending) | bus.update;
        end
    end

    // A digit is suppressed when it and every digit to its left are zero
    always_comb begin
        lz_blank_c = '0;
        zero_run_c = act_blank_lz;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_run_c    = zero_run_c && (act_digits[i] == 4'h0);
            lz_blank_c[i] = zero_run_c;
        end
    end

    assign sel_nibble_c = act_digits[idx];

    seg_hex_decode u_decode (
        .nibble (sel_nibble_c),
        .seg_c  (dec_seg_c)
    );

    // Next pin values for the currently scanned digit
    always_comb begin
        seg_c  = dec_seg_c;
        dp_n_c = ~act_dp[idx];
        an_c   = '1;
        if (lz_blank_c[idx]) begin
            seg_c = SEG_BLANK;
        end
        if (blink_phase && act_blink[idx]) begin
            seg_c  = SEG_BLANK;
            dp_n_c = 1'b1;
        end
        if ((presc != '0) && pwm_on_c) begin
            an_c[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
            an_q   <= '1;
        end else begin
            seg_q  <= seg_c;
            dp_n_q <= dp_n_c;
            an_q   <= an_c;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per digit slot (1 ms at 100 MHz); minimum 4.
REQ-003 Parameter PWM_BITS, default 4, brightness resolution.
REQ-004 Parameter BLINK_FRAMES, default 125, frames per blink half-period.
REQ-005 clk  in  1  system clock, 100 MHz nominal.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 digits  in  4*NUM_DIGITS  hex nibble per digit; digit i at [4i+3:4i]; digit 0 rightmost.
REQ-008 dp  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 blink_mask  in  NUM_DIGITS  1 = digit blinks.
REQ-010 blank_lz  in  1  1 = suppress leading zeros.
REQ-011 brightness  in  PWM_BITS  duty control; 0 = dark, all-ones = full.
REQ-012 update  in  1  single-cycle strobe; captures digits, dp, blink_mask, blank_lz into shadow registers.
REQ-013 seg  out  7  segment cathodes a..g at bits 0..6, active-low.
REQ-014 dp_n  out  1  decimal point cathode, active-low.
REQ-015 an  out  NUM_DIGITS  common-anode enables, active-low, at most one low.
REQ-016 frame_done  out  1  one-cycle pulse after last digit slot of each frame.

Function
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index SHALL advance i -> i+1, NUM_DIGITS-1 -> 0.
REQ-018 frame_done SHALL pulse in the cycle the index wraps NUM_DIGITS-1 -> 0.
REQ-019 Shadow-to-active copy SHALL occur only at the frame_done cycle when an update is pending; display content never changes mid-frame.
REQ-020 update coincident with frame_done SHALL be captured into shadow and copied at the next frame boundary, not the current one.
REQ-021 Multiple updates within one frame: last one wins.
REQ-022 Decode SHALL be full hex 0-F, standard font (b, d lowercase).
REQ-023 Digit i (i != 0) SHALL be blanked when active blank_lz = 1 and active digits NUM_DIGITS-1..i are all zero; digit 0 never suppressed; dp still honoured on suppressed digits.
REQ-024 Blink phase SHALL toggle every BLINK_FRAMES frames; when phase = 1, digits with blink_mask = 1 SHALL drive seg and dp_n all ones.
REQ-025 Free-running PWM counter, PWM_BITS wide; anode enabled while counter < brightness; brightness all-ones SHALL force continuous enable.
REQ-026 Dead time: all anodes high during prescaler value 0 of every slot, regardless of brightness.
REQ-027 seg, dp_n, an SHALL be registered; exactly one cycle latency from prescaler/index/PWM state to pins.
REQ-028 Blanked digit: anode still follows scan and PWM; seg = 7'h7F.
REQ-029 NUM_DIGITS = 1: index constant 0, frame_done pulses every slot.

Reset
REQ-030 While rst_n low: prescaler, index, PWM counter, blink counter and phase = 0; shadow, active, pending = 0; seg = 7'h7F, dp_n = 1, an all ones, frame_done = 0.
REQ-031 Reset assertion mid-frame SHALL take effect immediately (asynchronous); release SHALL restart at digit 0, prescaler 0.
REQ-032 After reset, display shows "0" on digit 0 only if blank_lz is later loaded = 1; active reset contents show all zeros with blank_lz = 0.

Structure
REQ-033 Package seg_scan_pkg SHALL hold the seg7_t typedef, 16-entry hex font constant, and SEG_BLANK constant.
REQ-034 Sub-module seg_hex_decode (combinational nibble -> seg7_t) SHALL be instantiated once on the selected digit.

Verification
REQ-035 SCAN_DIV=8, NUM_DIGITS=4, brightness=F: an sequence E,D,B,7 each low 7 cycles, high 1 dead cycle; frame_done every 32 cycles.
REQ-036 update with digits=16'h12AF mid-frame: pins unchanged until next frame_done, then digit 0 seg = 7'h0E (F), digit 1 = 7'h08 (A).
REQ-037 digits=16'h0050, blank_lz=1: digits 3, 2 seg = 7'h7F; digit 1 = 7'h12 (5); digit 0 = 7'h40 (0).
REQ-038 brightness=4, PWM_BITS=4: anode low 4 of each 16 PWM cycles (excluding dead cycle); brightness=0: an all ones.
REQ-039 BLINK_FRAMES=2, blink_mask=4'b0001: digit 0 blank during frames 2-3, 6-7; other digits constant.
REQ-040 rst_n low mid-slot: an, seg, dp_n all ones same cycle; after release first anode low is digit 0 at prescaler 1.
